duck_round_scheduler: RTL and testbench
=======================================

Name: duck_round_scheduler

Overview:
- Sequences gameplay while the game control FSM is in its running state.
- Spawns ducks after a fixed delay, tracks ammo per duck, counts hits per round and advances rounds.
- Accumulates score and raises game_finished, which feeds the game control FSM's game_finished input.
- Sits between the game control FSM, the mouse interface and the duck motion/hit-detect logic.

Parameters:
- DUCKS_PER_ROUND, 10: ducks spawned per round (1..15).
- ROUNDS, 5: rounds per game (1..15).
- SHOTS_PER_DUCK, 3: ammo loaded at each spawn (1..3).
- MIN_HITS, 6: hits required in a round to continue (0..DUCKS_PER_ROUND).
- SPAWN_DELAY, 65_000_000: clk cycles from entering SPAWN_WAIT to the duck_spawn pulse (>=1).
- HIT_POINTS, 100: score added per hit.
- BONUS_POINTS, 1000: perfect-round bonus; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- game_enable_posedge  in  1  one-cycle start pulse from the game control FSM
- game_enable  in  1  level, high while the game is running
- left_mouse  in  1  mouse button level; rising edge detected internally
- duck_hit  in  1  one-cycle pulse: active duck was hit
- duck_escaped  in  1  one-cycle pulse: active duck left the screen
- duck_spawn  out  1  one-cycle pulse that launches a duck
- duck_active  out  1  high while a duck is in flight
- ammo  out  2  remaining shots
- round_num  out  4  current round, 1-based
- duck_idx  out  4  index of the current duck within the round, 0-based
- hits  out  4  hits in the current round
- score  out  16  game score, saturating
- game_finished  out  1  level, high when the game is over

Behaviour:
- Reset: synchronous, active-high; reset rst, synchronous, active-high; clock clk.
- Reset values: all outputs 0; state IDLE; delay counter 0; mouse edge register 0.
- All outputs are registered.
- shot = left_mouse & ~left_mouse_q (registered previous value).
- IDLE:
  - On game_enable_posedge: round_num<=1, duck_idx<=0, hits<=0, score<=0, counter<=0; go to SPAWN_WAIT.
- SPAWN_WAIT:
  - Counter increments each cycle.
  - When counter==SPAWN_DELAY-1: duck_spawn<=1 for exactly one cycle, duck_active<=1, ammo<=SHOTS_PER_DUCK, counter<=0; go to DUCK_FLY.
  - Spawn pulse occurs SPAWN_DELAY cycles after state entry.
- DUCK_FLY:
  - shot with ammo>0: ammo-1. Shot with ammo==0 is ignored; ammo never wraps.
  - duck_hit: hits+1, score+HIT_POINTS saturating at 16'hFFFF; go to DUCK_DONE.
  - duck_escaped without duck_hit: go to DUCK_DONE.
  - duck_hit and duck_escaped in the same cycle: counted as a hit.
  - shot and duck_hit in the same cycle: both take effect.
  - Ammo reaching 0 does not end the duck; the duck logic reports the escape.
- DUCK_DONE (1 cycle):
  - duck_active<=0.
  - If duck_idx==DUCKS_PER_ROUND-1: go to ROUND_END.
  - Else duck_idx+1 and go to SPAWN_WAIT.
- ROUND_END (1 cycle):
  - If hits<MIN_HITS or round_num==ROUNDS: go to FINISHED.
  - Else round_num+1, duck_idx<=0, hits<=0; go to SPAWN_WAIT.
- FINISHED:
  - game_finished<=1, duck_active<=0, ammo<=0.
  - round_num, hits and score hold.
  - game_enable_posedge restarts the game as from IDLE and clears game_finished.
  - Otherwise FINISHED is held until rst.
- Abort: game_enable==0 in SPAWN_WAIT, DUCK_FLY, DUCK_DONE or ROUND_END:
  - Next cycle go to IDLE with duck_active, ammo and duck_spawn cleared.
  - score and round_num hold.
- Inputs in IDLE: duck_hit, duck_escaped and shot are ignored.
- Illegal state encoding: go to IDLE.

Optional Feature:
- Macro: DUCK_PERFECT_BONUS_EN.
- Defined: in ROUND_END, if hits==DUCKS_PER_ROUND, score+BONUS_POINTS (saturating) in the same cycle as the round decision.
- Undefined: no bonus logic, and BONUS_POINTS is unused.

Test Plan:
Bench parameters for all scenarios: DUCKS_PER_ROUND=2, ROUNDS=2, SHOTS_PER_DUCK=3, MIN_HITS=1, SPAWN_DELAY=4, HIT_POINTS=100.
1. Reset, then game_enable_posedge -> duck_spawn pulses exactly 4 cycles later; ammo=3, duck_active=1, round_num=1.
2. Three shot edges, then a fourth, then duck_escaped -> ammo 2,1,0,0; duck_idx becomes 1; next spawn 4 cycles after SPAWN_WAIT entry.
3. Round 1: hit, escape. Round 2: hit, hit -> score=300; round_num=2 then game_finished=1; score holds 300 (bonus macro off).
4. Round 1 with two escapes -> hits=0<MIN_HITS; game_finished=1 after round 1, round_num=1.
5. duck_hit and duck_escaped in the same cycle -> hits+1, score+100. Deassert game_enable mid-flight -> IDLE, duck_active=0, ammo=0.
6. DUCK_PERFECT_BONUS_EN defined, BONUS_POINTS=1000, two hits in round 1 -> score=1200 after ROUND_END. Preload score near 16'hFFFF -> score saturates at 16'hFFFF.

Source files
------------

// File: rtl/duck_round_scheduler.sv
// Gameplay sequencer: spawns ducks, tracks ammo, hits, rounds and score.
// Optional perfect-round bonus is compiled in with `define DUCK_PERFECT_BONUS_EN.
module duck_round_scheduler #(
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned ROUNDS          = 5,
    parameter int unsigned SHOTS_PER_DUCK  = 3,
    parameter int unsigned MIN_HITS        = 6,
    parameter int unsigned SPAWN_DELAY     = 65_000_000,
    parameter int unsigned HIT_POINTS      = 100
`ifdef DUCK_PERFECT_BONUS_EN
    ,
    parameter int unsigned BONUS_POINTS    = 1000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable_posedge,
    input  logic        game_enable,
    input  logic        left_mouse,
    input  logic        duck_hit,
    input  logic        duck_escaped,
    output logic        duck_spawn,
    output logic        duck_active,
    output logic [1:0]  ammo,
    output logic [3:0]  round_num,
    output logic [3:0]  duck_idx,
    output logic [3:0]  hits,
    output logic [15:0] score,
    output logic        game_finished
);

    localparam int unsigned CntW = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SPAWN_DELAY - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSpawnWait,
        StDuckFly,
        StDuckDone,
        StRoundEnd,
        StFinished
    } state_t;

    state_t          state;
    logic [CntW-1:0] counter;
    logic            left_mouse_q;
    logic            shot;
    logic            start;
    logic            abort;
    logic [31:0]     hit_sum;
    logic [15:0]     score_hit;
`ifdef DUCK_PERFECT_BONUS_EN
    logic [31:0]     bonus_sum;
    logic [15:0]     score_bonus;
`endif

    always_comb begin
        shot      = left_mouse & ~left_mouse_q;
        start     = game_enable_posedge && (state == StIdle || state == StFinished);
        abort     = !game_enable && (state == StSpawnWait || state == StDuckFly ||
                                     state == StDuckDone || state == StRoundEnd);
        hit_sum   = 32'(score) + 32'(HIT_POINTS);
        score_hit = (hit_sum > 32'h0000_FFFF) ? 16'hFFFF : hit_sum[15:0];
`ifdef DUCK_PERFECT_BONUS_EN
        bonus_sum   = 32'(score) + 32'(BONUS_POINTS);
        score_bonus = (bonus_sum > 32'h0000_FFFF) ? 16'hFFFF : bonus_sum[15:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            counter       <= '0;
            left_mouse_q  <= 1'b0;
            duck_spawn    <= 1'b0;
            duck_active   <= 1'b0;
            ammo          <= 2'd0;
            round_num     <= 4'd0;
            duck_idx      <= 4'd0;
            hits          <= 4'd0;
            score         <= 16'd0;
            game_finished <= 1'b0;
        end else begin
            left_mouse_q <= left_mouse;
            duck_spawn   <= 1'b0;
            if (abort) begin
                // Score and round are left visible after an abort.
                state       <= StIdle;
                duck_active <= 1'b0;
                ammo        <= 2'd0;
                counter     <= '0;
            end else if (start) begin
                state         <= StSpawnWait;
                round_num     <= 4'd1;
                duck_idx      <= 4'd0;
                hits          <= 4'd0;
                score         <= 16'd0;
                counter       <= '0;
                game_finished <= 1'b0;
            end else begin
                case (state)
                    StIdle: ;
                    StSpawnWait: begin
                        if (counter == CntLast) begin
                            duck_spawn  <= 1'b1;
                            duck_active <= 1'b1;
                            ammo        <= 2'(SHOTS_PER_DUCK);
                            counter     <= '0;
                            state       <= StDuckFly;
                        end else begin
                            counter <= counter + CntOne;
                        end
                    end
                    StDuckFly: begin
                        if (shot && ammo != 2'd0) begin
                            ammo <= ammo - 2'd1;
                        end
                        // A simultaneous escape still counts as a hit.
                        if (duck_hit) begin
                            hits  <= hits + 4'd1;
                            score <= score_hit;
                            state <= StDuckDone;
                        end else if (duck_escaped) begin
                            state <= StDuckDone;
                        end
                    end
                    StDuckDone: begin
                        duck_active <= 1'b0;
                        if (duck_idx == 4'(DUCKS_PER_ROUND - 1)) begin
                            state <= StRoundEnd;
                        end else begin
                            duck_idx <= duck_idx + 4'd1;
                            counter  <= '0;
                            state    <= StSpawnWait;
                        end
                    end
                    StRoundEnd: begin
`ifdef DUCK_PERFECT_BONUS_EN
                        if (hits == 4'(DUCKS_PER_ROUND)) begin
                            score <= score_bonus;
                        end
`endif
                        if (hits < 4'(MIN_HITS) || round_num == 4'(ROUNDS)) begin
                            state         <= StFinished;
                            game_finished <= 1'b1;
                            duck_active   <= 1'b0;
                            ammo          <= 2'd0;
                        end else begin
                            round_num <= round_num + 4'd1;
                            duck_idx  <= 4'd0;
                            hits      <= 4'd0;
                            counter   <= '0;
                            state     <= StSpawnWait;
                        end
                    end
                    StFinished: begin
                        game_finished <= 1'b1;
                        duck_active   <= 1'b0;
                        ammo          <= 2'd0;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_duck_round_scheduler.sv
// Self-checking bench for duck_round_scheduler: directed scenarios plus random games
// checked against a game-level reference model (two instances share the stimulus).
module tb_duck_round_scheduler;

    localparam int D   = 2;
    localparam int R   = 2;
    localparam int S   = 3;
    localparam int MH  = 1;
    localparam int SD  = 4;
    localparam int HP  = 100;
    localparam int HP2 = 30000;
    localparam int BP  = 1000;
`ifdef DUCK_PERFECT_BONUS_EN
    localparam int BonusOn = 1;
`else
    localparam int BonusOn = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic game_enable_posedge = 1'b0;
    logic game_enable = 1'b0;
    logic left_mouse = 1'b0;
    logic duck_hit = 1'b0;
    logic duck_escaped = 1'b0;

    logic        duck_spawn, duck_active, game_finished;
    logic [1:0]  ammo;
    logic [3:0]  round_num, duck_idx, hits;
    logic [15:0] score;
    logic        duck_spawn2, duck_active2, game_finished2;
    logic [1:0]  ammo2;
    logic [3:0]  round_num2, duck_idx2, hits2;
    logic [15:0] score2;

    int total = 0;
    int bad = 0;

    // Game-level reference model
    int m_round, m_idx, m_hits, m_total, m_bonus;
    bit m_finished;

    always #5 clk = ~clk;

    duck_round_scheduler #(
        .DUCKS_PER_ROUND(D), .ROUNDS(R), .SHOTS_PER_DUCK(S), .MIN_HITS(MH),
        .SPAWN_DELAY(SD), .HIT_POINTS(HP)
    ) dut (
        .clk(clk), .rst(rst), .game_enable_posedge(game_enable_posedge),
        .game_enable(game_enable), .left_mouse(left_mouse), .duck_hit(duck_hit),
        .duck_escaped(duck_escaped), .duck_spawn(duck_spawn), .duck_active(duck_active),
        .ammo(ammo), .round_num(round_num), .duck_idx(duck_idx), .hits(hits),
        .score(score), .game_finished(game_finished)
    );

    duck_round_scheduler #(
        .DUCKS_PER_ROUND(D), .ROUNDS(R), .SHOTS_PER_DUCK(S), .MIN_HITS(MH),
        .SPAWN_DELAY(SD), .HIT_POINTS(HP2)
    ) dut_sat (
        .clk(clk), .rst(rst), .game_enable_posedge(game_enable_posedge),
        .game_enable(game_enable), .left_mouse(left_mouse), .duck_hit(duck_hit),
        .duck_escaped(duck_escaped), .duck_spawn(duck_spawn2), .duck_active(duck_active2),
        .ammo(ammo2), .round_num(round_num2), .duck_idx(duck_idx2), .hits(hits2),
        .score(score2), .game_finished(game_finished2)
    );

    function automatic int exp_score(input int hp);
        int s;
        s = m_total * hp + m_bonus * BP * BonusOn;
        return (s > 65535) ? 65535 : s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game();
        game_enable = 1'b1;
        game_enable_posedge = 1'b1;
        step();
        game_enable_posedge = 1'b0;
        m_round = 1; m_idx = 0; m_hits = 0; m_total = 0; m_bonus = 0; m_finished = 0;
        total++;
        if (game_finished !== 1'b0 || round_num !== 4'd1 || score !== 16'd0 ||
            hits !== 4'd0 || duck_idx !== 4'd0) begin
            bad++;
            $display("FAIL start got fin=%b rnd=%0d sc=%0d hits=%0d idx=%0d want 0,1,0,0,0",
                     game_finished, round_num, score, hits, duck_idx);
        end
    endtask

    // outcome: 0 escape, 1 hit, 2 hit and escape together
    task automatic play_duck(input int shots, input int outcome, input bit shot_at_end);
        int n;
        int exp_ammo;
        n = 0;
        while (duck_spawn !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n != SD) begin
            bad++;
            $display("FAIL spawn_delay got=%0d want=%0d", n, SD);
        end
        total++;
        if (ammo !== 2'(S) || duck_active !== 1'b1 || round_num !== 4'(m_round) ||
            duck_idx !== 4'(m_idx)) begin
            bad++;
            $display("FAIL spawn_state got ammo=%0d act=%b rnd=%0d idx=%0d want %0d,1,%0d,%0d",
                     ammo, duck_active, round_num, duck_idx, S, m_round, m_idx);
        end
        step();
        total++;
        if (duck_spawn !== 1'b0) begin
            bad++;
            $display("FAIL spawn_pulse got=%b want=0", duck_spawn);
        end
        exp_ammo = S;
        for (int i = 0; i < shots; i++) begin
            left_mouse = 1'b1;
            step();
            left_mouse = 1'b0;
            if (exp_ammo > 0) exp_ammo--;
            total++;
            if (ammo !== 2'(exp_ammo)) begin
                bad++;
                $display("FAIL ammo_shot got=%0d want=%0d", ammo, exp_ammo);
            end
            step();
        end
        duck_hit = (outcome != 0);
        duck_escaped = (outcome != 1);
        left_mouse = shot_at_end;
        step();
        duck_hit = 1'b0;
        duck_escaped = 1'b0;
        left_mouse = 1'b0;
        if (shot_at_end && exp_ammo > 0) exp_ammo--;
        if (outcome != 0) begin
            m_hits++;
            m_total++;
        end
        total++;
        if (ammo !== 2'(exp_ammo) || hits !== 4'(m_hits) || score !== 16'(exp_score(HP))) begin
            bad++;
            $display("FAIL duck_end got ammo=%0d hits=%0d sc=%0d want %0d,%0d,%0d",
                     ammo, hits, score, exp_ammo, m_hits, exp_score(HP));
        end
        step();
        total++;
        if (duck_active !== 1'b0) begin
            bad++;
            $display("FAIL duck_done_active got=%b want=0", duck_active);
        end
        if (m_idx < D - 1) begin
            m_idx++;
            total++;
            if (duck_idx !== 4'(m_idx)) begin
                bad++;
                $display("FAIL duck_idx got=%0d want=%0d", duck_idx, m_idx);
            end
        end else begin
            step();
            if (m_hits == D) m_bonus++;
            if (m_hits < MH || m_round == R) begin
                m_finished = 1;
            end else begin
                m_round++;
                m_idx = 0;
                m_hits = 0;
            end
            total++;
            if (game_finished !== m_finished || round_num !== 4'(m_round) ||
                hits !== 4'(m_hits) || score !== 16'(exp_score(HP)) ||
                score2 !== 16'(exp_score(HP2))) begin
                bad++;
                $display("FAIL round_end got fin=%b rnd=%0d hits=%0d sc=%0d sc2=%0d want %b,%0d,%0d,%0d,%0d",
                         game_finished, round_num, hits, score, score2, m_finished, m_round,
                         m_hits, exp_score(HP), exp_score(HP2));
            end
            if (m_finished) begin
                total++;
                if (ammo !== 2'd0 || duck_active !== 1'b0) begin
                    bad++;
                    $display("FAIL finished_clear got ammo=%0d act=%b want 0,0", ammo, duck_active);
                end
            end
        end
    endtask

    task automatic abort_game();
        game_enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (duck_spawn !== 1'b0 || duck_active !== 1'b0 || ammo !== 2'd0 ||
            round_num !== 4'd0 || duck_idx !== 4'd0 || hits !== 4'd0 ||
            score !== 16'd0 || game_finished !== 1'b0) begin
            bad++;
            $display("FAIL reset got sp=%b act=%b ammo=%0d rnd=%0d idx=%0d hits=%0d sc=%0d fin=%b want all 0",
                     duck_spawn, duck_active, ammo, round_num, duck_idx, hits, score,
                     game_finished);
        end
        rst = 1'b0;
        // Idle ignores hits, escapes and shots
        duck_hit = 1'b1; duck_escaped = 1'b1; left_mouse = 1'b1;
        step();
        duck_hit = 1'b0; duck_escaped = 1'b0; left_mouse = 1'b0;
        for (int i = 0; i < 6; i++) step();
        total++;
        if (hits !== 4'd0 || score !== 16'd0 || duck_active !== 1'b0 || ammo !== 2'd0) begin
            bad++;
            $display("FAIL idle_ignore got hits=%0d sc=%0d act=%b ammo=%0d want 0,0,0,0",
                     hits, score, duck_active, ammo);
        end
    endtask

    task automatic test_ammo_and_spawn();
        start_game();
        play_duck(4, 0, 1'b0);
        play_duck(1, 1, 1'b0);
        abort_game();
    endtask

    task automatic test_full_game();
        start_game();
        play_duck(0, 1, 1'b0);
        play_duck(2, 0, 1'b0);
        play_duck(1, 1, 1'b0);
        play_duck(3, 1, 1'b0);
        for (int i = 0; i < 8; i++) step();
        total++;
        if (score !== 16'(300 + BonusOn * BP) || game_finished !== 1'b1 || round_num !== 4'd2) begin
            bad++;
            $display("FAIL game_hold got sc=%0d fin=%b rnd=%0d want %0d,1,2",
                     score, game_finished, round_num, 300 + BonusOn * BP);
        end
    endtask

    task automatic test_early_finish();
        start_game();
        play_duck(0, 0, 1'b0);
        play_duck(1, 0, 1'b0);
        total++;
        if (game_finished !== 1'b1 || round_num !== 4'd1 || hits !== 4'd0) begin
            bad++;
            $display("FAIL early_finish got fin=%b rnd=%0d hits=%0d want 1,1,0",
                     game_finished, round_num, hits);
        end
    endtask

    task automatic test_hit_escape_abort();
        int n;
        bit seen;
        start_game();
        play_duck(0, 2, 1'b1);
        n = 0;
        while (duck_spawn !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n != SD) begin
            bad++;
            $display("FAIL abort_spawn got=%0d want=%0d", n, SD);
        end
        left_mouse = 1'b1;
        step();
        left_mouse = 1'b0;
        game_enable = 1'b0;
        step();
        total++;
        if (duck_active !== 1'b0 || ammo !== 2'd0 || duck_spawn !== 1'b0 ||
            score !== 16'd100 || round_num !== 4'd1 || hits !== 4'd1) begin
            bad++;
            $display("FAIL abort got act=%b ammo=%0d sp=%b sc=%0d rnd=%0d hits=%0d want 0,0,0,100,1,1",
                     duck_active, ammo, duck_spawn, score, round_num, hits);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (duck_spawn === 1'b1 || duck_active === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle got spawn_seen=%b want=0", seen);
        end
    endtask

    task automatic test_bonus_saturation();
        start_game();
        play_duck(0, 1, 1'b0);
        play_duck(0, 1, 1'b0);
        total++;
        if (score !== 16'(200 + BonusOn * BP)) begin
            bad++;
            $display("FAIL bonus got=%0d want=%0d", score, 200 + BonusOn * BP);
        end
        play_duck(1, 1, 1'b0);
        play_duck(0, 1, 1'b0);
        total++;
        if (score2 !== 16'hFFFF) begin
            bad++;
            $display("FAIL saturate got=%0d want=65535", score2);
        end
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 8; g++) begin
            start_game();
            while (!m_finished) begin
                play_duck(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ammo_and_spawn();
        test_full_game();
        test_early_finish();
        test_hit_escape_abort();
        test_bonus_saturation();
        test_random_games();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
